// File: rtl/pwr_seq_pkg.sv
// Shared encodings for the power-enable sequencer: activity-pattern modes and FSM states.
package pwr_seq_pkg;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_SWEEP = 2'd1;
    localparam logic [1:0] MODE_ALL   = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_ON   = 2'd2
    } state_e;

endpackage

// File: rtl/pwr_pattern_gen.sv
// Combinational enable-pattern lookup: thermometer (RAMP), one-hot (SWEEP) or all-on (ALL).
module pwr_pattern_gen
    import pwr_seq_pkg::*;
#(
    parameter int unsigned NUM_MODULES = 32,
    parameter int unsigned STEP_W      = 5
) (
    input  logic [1:0]             mode_i,
    input  logic [STEP_W-1:0]      step_i,
    output logic [NUM_MODULES-1:0] pattern_o
);

    // NOTE: assigning the whole output before the loop keeps every bit driven on every path, so no latch is inferred.
    always_comb begin
        pattern_o = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            case (mode_i)
                MODE_RAMP:  pattern_o[i] = (i <= int'(step_i));
                MODE_SWEEP: pattern_o[i] = (i == int'(step_i));
                MODE_ALL:   pattern_o[i] = 1'b1;
                default:    pattern_o[i] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pwr_en_sequencer.sv
// Steps the user-array power-enable vector through RAMP/SWEEP/ALL patterns with a
// programmed ON dwell and optional all-off gap per step; all outputs are registered.
module pwr_en_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int unsigned NUM_MODULES = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned STEP_W      = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1
) (
    input  logic                   clk100m,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [CNT_W-1:0]       dwell_cycles,
    input  logic [CNT_W-1:0]       gap_cycles,
    output logic [NUM_MODULES-1:0] pwr_en_out,
    output logic [STEP_W-1:0]      step_idx,
    output logic                   step_strobe,
    output logic                   busy,
    output logic                   done
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_MODULES - 1);

    // A programmed dwell of zero still holds the pattern for one cycle.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [CNT_W-1:0] dwell);
        return (dwell == '0) ? '0 : dwell - CNT_W'(1);
    endfunction

    state_e                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [CNT_W-1:0]       dwell_q, dwell_d;
    logic [CNT_W-1:0]       gap_q, gap_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [STEP_W-1:0]      step_idx_q, step_idx_d;
    logic [NUM_MODULES-1:0] pwr_en_q, pwr_en_d;
    logic                   strobe_q, strobe_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   is_last;
    logic [1:0]             pat_mode;
    logic [NUM_MODULES-1:0] pattern;

    assign is_last  = (mode_q == MODE_ALL) ? (step_q == '0) : (step_q == LAST_STEP);
    // On the accepting edge the mode register is not loaded yet, so look at the input.
    assign pat_mode = (state_q == ST_IDLE) ? mode : mode_q;

    pwr_pattern_gen #(
        .NUM_MODULES (NUM_MODULES),
        .STEP_W      (STEP_W)
    ) u_pattern (
        .mode_i    (pat_mode),
        .step_i    (step_d),
        .pattern_o (pattern)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dwell_d    = dwell_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        step_idx_d = step_idx_q;
        strobe_d   = 1'b0;
        done_d     = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            if (state_q != ST_IDLE) begin
                step_d     = '0;
                step_idx_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (mode != MODE_RSVD)) begin
                        mode_d     = mode;
                        dwell_d    = dwell_cycles;
                        gap_d      = gap_cycles;
                        step_d     = '0;
                        step_idx_d = '0;
                        if (gap_cycles != '0) begin
                            state_d = ST_GAP;
                            cnt_d   = gap_cycles - CNT_W'(1);
                        end else begin
                            state_d  = ST_ON;
                            cnt_d    = dwell_load(dwell_cycles);
                            strobe_d = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d  = ST_ON;
                        cnt_d    = dwell_load(dwell_q);
                        strobe_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (cnt_q == '0) begin
                        if (is_last) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            step_d = step_q + STEP_W'(1);
                            if (gap_q != '0) begin
                                state_d = ST_GAP;
                                cnt_d   = gap_q - CNT_W'(1);
                            end else begin
                                cnt_d    = dwell_load(dwell_q);
                                strobe_d = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // The visible step number only advances when its ON phase begins.
        if (strobe_d) begin
            step_idx_d = step_d;
        end
        busy_d   = (state_d != ST_IDLE);
        pwr_en_d = (state_d == ST_ON) ? pattern : '0;
    end

    // NOTE: non-blocking assignments make every register sample the pre-edge values, so ordering here does not matter.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_RAMP;
            dwell_q    <= '0;
            gap_q      <= '0;
            cnt_q      <= '0;
            step_q     <= '0;
            step_idx_q <= '0;
            pwr_en_q   <= '0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            dwell_q    <= dwell_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            step_idx_q <= step_idx_d;
            pwr_en_q   <= pwr_en_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pwr_en_out  = pwr_en_q;
    assign step_idx    = step_idx_q;
    assign step_strobe = strobe_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pwr_en_sequencer.sv
// Self-checking bench: cycle-by-cycle comparison against a per-step trace model built from the pattern rules.
module tb_pwr_en_sequencer;
    import pwr_seq_pkg::*;

    localparam int NM = 4;
    localparam int CW = 8;
    localparam int SW = 2;

    logic          clk100m = 1'b0;
    logic          rstn    = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic [1:0]    mode    = 2'd0;
    logic [CW-1:0] dwell_cycles = '0;
    logic [CW-1:0] gap_cycles   = '0;
    logic [NM-1:0] pwr_en_out;
    logic [SW-1:0] step_idx;
    logic          step_strobe;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NM-1:0] pwr;
        logic          busy;
        logic          strobe;
        logic          done;
        logic [SW-1:0] idx;
        bit            chk_idx;
    } exp_t;

    pwr_en_sequencer #(
        .NUM_MODULES (NM),
        .CNT_W       (CW),
        .STEP_W      (SW)
    ) dut (
        .clk100m      (clk100m),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .dwell_cycles (dwell_cycles),
        .gap_cycles   (gap_cycles),
        .pwr_en_out   (pwr_en_out),
        .step_idx     (step_idx),
        .step_strobe  (step_strobe),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk100m = ~clk100m;

    function automatic logic [NM-1:0] model_pattern(input int m, input int s);
        logic [NM-1:0] p;
        if (m == 0)      p = NM'((1 << (s + 1)) - 1);
        else if (m == 1) p = NM'(1 << s);
        else             p = '1;
        return p;
    endfunction

    // Starts a run from the current negedge and checks every cycle through the done cycle,
    // or, with abort_at >= 0, asserts abort after that trace entry and checks the recovery.
    task automatic run_sequence(input logic [1:0] m, input int dw, input int gp,
                                input bit noise, input int abort_at, input string name);
        exp_t q[$];
        exp_t e;
        int   steps;
        int   d;
        int   last;
        start        = 1'b1;
        abort        = 1'b0;
        mode         = m;
        dwell_cycles = CW'(dw);
        gap_cycles   = CW'(gp);
        steps = (m == MODE_ALL) ? 1 : NM;
        d     = (dw == 0) ? 1 : dw;
        for (int s = 0; s < steps; s++) begin
            for (int g = 0; g < gp; g++) begin
                e.pwr = '0; e.busy = 1'b1; e.strobe = 1'b0; e.done = 1'b0;
                e.idx = SW'((s == 0) ? 0 : s - 1); e.chk_idx = 1'b1;
                q.push_back(e);
            end
            for (int k = 0; k < d; k++) begin
                e.pwr = model_pattern(int'(m), s); e.busy = 1'b1; e.strobe = (k == 0);
                e.done = 1'b0; e.idx = SW'(s); e.chk_idx = 1'b1;
                q.push_back(e);
            end
        end
        e.pwr = '0; e.busy = 1'b0; e.strobe = 1'b0; e.done = 1'b1; e.idx = '0; e.chk_idx = 1'b0;
        q.push_back(e);
        if (abort_at < 0) begin
            last = q.size() - 1;
        end else begin
            last = abort_at;
            e.pwr = '0; e.busy = 1'b0; e.strobe = 1'b0; e.done = 1'b0; e.idx = '0; e.chk_idx = 1'b1;
            q[abort_at + 1] = e;
            last = abort_at + 1;
        end

        for (int k = 0; k <= last; k++) begin
            @(posedge clk100m);
            @(negedge clk100m);
            n_checks++;
            if ({pwr_en_out, busy, step_strobe, done} !== {q[k].pwr, q[k].busy, q[k].strobe, q[k].done} ||
                (q[k].chk_idx && step_idx !== q[k].idx)) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got pwr_en_out=%b busy=%b strobe=%b done=%b step_idx=%0d, want pwr_en_out=%b busy=%b strobe=%b done=%b step_idx=%0d%s",
                         name, k + 1, pwr_en_out, busy, step_strobe, done, step_idx,
                         q[k].pwr, q[k].busy, q[k].strobe, q[k].done, q[k].idx,
                         q[k].chk_idx ? "" : " (idx not checked)");
            end
            if (k == abort_at) begin
                start = 1'b0;
                abort = 1'b1;
            end else if (k == last) begin
                start = 1'b0;
                abort = 1'b0;
            end else if (noise) begin
                start        = 1'($urandom_range(0, 1));
                mode         = 2'($urandom_range(0, 3));
                dwell_cycles = CW'($urandom);
                gap_cycles   = CW'($urandom);
            end else begin
                start = 1'b0;
            end
        end

        if (abort_at >= 0) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk100m);
                @(negedge clk100m);
                n_checks++;
                if ({pwr_en_out, busy, step_strobe, done} !== '0) begin
                    n_fail++;
                    $display("FAIL %s post-abort %0d: got pwr_en_out=%b busy=%b strobe=%b done=%b, want all 0",
                             name, k, pwr_en_out, busy, step_strobe, done);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk100m);
        n_checks++;
        if ({pwr_en_out, step_idx, busy, step_strobe, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got pwr_en_out=%b step_idx=%0d busy=%b strobe=%b done=%b, want all 0",
                     pwr_en_out, step_idx, busy, step_strobe, done);
        end
        rstn = 1'b1;
    endtask

    task automatic test_ramp();
        run_sequence(MODE_RAMP, 3, 0, 1'b0, -1, "ramp_d3_g0");
    endtask

    task automatic test_sweep();
        run_sequence(MODE_SWEEP, 2, 2, 1'b0, -1, "sweep_d2_g2");
    endtask

    task automatic test_all();
        run_sequence(MODE_ALL, 0, 0, 1'b0, -1, "all_d0");
    endtask

    task automatic test_reserved();
        start        = 1'b1;
        mode         = MODE_RSVD;
        dwell_cycles = CW'(2);
        gap_cycles   = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk100m);
            @(negedge clk100m);
            if (k == 1) start = 1'b0;
            n_checks++;
            if ({pwr_en_out, busy, step_strobe, done} !== '0) begin
                n_fail++;
                $display("FAIL reserved_mode cycle %0d: got pwr_en_out=%b busy=%b strobe=%b done=%b, want all 0",
                         k, pwr_en_out, busy, step_strobe, done);
            end
        end
    endtask

    task automatic test_busy_noise();
        run_sequence(MODE_RAMP, 2, 1, 1'b1, -1, "ramp_start_while_busy");
    endtask

    task automatic test_back_to_back();
        run_sequence(MODE_ALL, 1, 0, 1'b0, -1, "b2b_first");
        run_sequence(MODE_SWEEP, 1, 0, 1'b0, -1, "b2b_second");
    endtask

    task automatic test_abort();
        int gp;
        int dw;
        int at;
        gp = $urandom_range(0, 3);
        dw = $urandom_range(1, 4);
        at = 2 * (gp + dw) + gp + $urandom_range(0, dw - 1);
        run_sequence(MODE_RAMP, dw, gp, 1'b1, at, "abort_step2_on");
        start = 1'b1;
        abort = 1'b1;
        mode  = MODE_RAMP;
        @(posedge clk100m);
        @(negedge clk100m);
        start = 1'b0;
        abort = 1'b0;
        n_checks++;
        if ({pwr_en_out, busy, step_strobe, done} !== '0) begin
            n_fail++;
            $display("FAIL abort_with_start_idle: got pwr_en_out=%b busy=%b strobe=%b done=%b, want all 0",
                     pwr_en_out, busy, step_strobe, done);
        end
    endtask

    task automatic test_reset_mid_gap();
        start        = 1'b1;
        mode         = MODE_RAMP;
        dwell_cycles = CW'(2);
        gap_cycles   = CW'(3);
        @(posedge clk100m);
        @(negedge clk100m);
        start = 1'b0;
        repeat (10) @(posedge clk100m);
        @(negedge clk100m);
        n_checks++;
        if (busy !== 1'b1 || step_idx !== SW'(1) || pwr_en_out !== '0) begin
            n_fail++;
            $display("FAIL pre_reset_gap: got busy=%b step_idx=%0d pwr_en_out=%b, want busy=1 step_idx=1 pwr_en_out=0",
                     busy, step_idx, pwr_en_out);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({pwr_en_out, step_idx, busy, step_strobe, done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got pwr_en_out=%b step_idx=%0d busy=%b strobe=%b done=%b, want all 0",
                     pwr_en_out, step_idx, busy, step_strobe, done);
        end
        repeat (2) @(negedge clk100m);
        rstn = 1'b1;
        run_sequence(MODE_RAMP, 2, 3, 1'b0, -1, "ramp_after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            run_sequence(2'($urandom_range(0, 2)), $urandom_range(0, 5), $urandom_range(0, 3),
                         1'b1, -1, $sformatf("random_%0d", r));
        end
    endtask

    task automatic test_max_counters();
        run_sequence(MODE_ALL, 255, 255, 1'b0, -1, "all_max_dwell_gap");
        run_sequence(MODE_SWEEP, 255, 0, 1'b1, -1, "sweep_max_dwell");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_sweep();
        test_all();
        test_reserved();
        test_busy_noise();
        test_back_to_back();
        test_abort();
        test_reset_mid_gap();
        test_random();
        test_max_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
